// File: rtl/hidden_layer_collector.sv
// Collects delayed dot-product results, adds bias, saturates and packs a layer vector.
// Define ACT_RELU_EN to clamp negative activations to zero (hidden layers).
module hidden_layer_collector #(
    parameter int NUM_NEURONS = 16,
    parameter int DATA_W      = 16,
    parameter int PIPE_LAT    = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue,
    output logic                          issue_ready,
    input  logic [DATA_W-1:0]             bias_in,
    input  logic [DATA_W-1:0]             dot_in,
    output logic [NUM_NEURONS*DATA_W-1:0] layer_out,
    output logic                          layer_valid,
    input  logic                          layer_ready,
    output logic                          sat_flag
);

    localparam int CW = $clog2(NUM_NEURONS + 1);
    localparam int SW = $clog2(NUM_NEURONS);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       idx;
    logic [CW-1:0]       inflight;
    logic [CW:0]         occupancy;
    logic [PIPE_LAT-1:0] dl_valid;
    logic [DATA_W-1:0]   dl_bias [PIPE_LAT];
    logic [DATA_W-1:0]   slots [NUM_NEURONS];
    logic                accept;
    logic                tvalid;
    logic                handshake;
    logic                last_slot;
    logic                clipped;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   sat_val;
    logic [DATA_W-1:0]   act_val;

    assign accept    = issue && issue_ready;
    assign tvalid    = dl_valid[PIPE_LAT-1];
    assign handshake = layer_valid && layer_ready;
    assign last_slot = tvalid && (idx == CW'(NUM_NEURONS - 1));
    assign occupancy = {1'b0, idx} + {1'b0, inflight};

    // Bias travels alongside the issue marker so it meets its own dot result.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) dl_bias[i] <= '0;
        end else begin
            dl_valid[0] <= accept;
            dl_bias[0]  <= bias_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_bias[i]  <= dl_bias[i-1];
            end
        end
    end

    always_comb begin
        sum     = {dot_in[DATA_W-1], dot_in} + {dl_bias[PIPE_LAT-1][DATA_W-1], dl_bias[PIPE_LAT-1]};
        clipped = (sum[DATA_W] != sum[DATA_W-1]);
        if (clipped)
            sat_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_val = sum[DATA_W-1:0];
`ifdef ACT_RELU_EN
        act_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
        act_val = sat_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (last_slot)   state_next = FULL;
            FULL:    if (layer_ready) state_next = COLLECT;
        endcase
    end

    always_comb begin
        layer_valid = (state == FULL);
        issue_ready = (state == COLLECT) && (occupancy < (CW+1)'(NUM_NEURONS));
    end

    // No tap can fire in FULL, so the handshake clear never races a slot write.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            inflight <= '0;
            sat_flag <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) slots[k] <= '0;
        end else begin
            if (handshake) begin
                idx      <= '0;
                sat_flag <= 1'b0;
            end else if (tvalid) begin
                slots[idx[SW-1:0]] <= act_val;
                idx                <= idx + CW'(1);
                if (clipped) sat_flag <= 1'b1;
            end
            case ({accept, tvalid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_pack
        assign layer_out[k*DATA_W +: DATA_W] = slots[k];
    end

endmodule

// File: tb/tb_hidden_layer_collector.sv
// Randomized scoreboard bench for hidden_layer_collector; honours ACT_RELU_EN like the RTL.
module tb_hidden_layer_collector;

    localparam int N = 16;
    localparam int W = 16;
    localparam int L = 11;

    logic           clk = 1'b0;
    logic           reset;
    logic           issue;
    logic           issue_ready;
    logic [W-1:0]   bias_in;
    logic [W-1:0]   dot_in;
    logic [N*W-1:0] layer_out;
    logic           layer_valid;
    logic           layer_ready;
    logic           sat_flag;

    hidden_layer_collector #(.NUM_NEURONS(N), .DATA_W(W), .PIPE_LAT(L)) dut (
        .clk(clk), .reset(reset), .issue(issue), .issue_ready(issue_ready),
        .bias_in(bias_in), .dot_in(dot_in), .layer_out(layer_out),
        .layer_valid(layer_valid), .layer_ready(layer_ready), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct { int edge_no; logic [W-1:0] bias; logic [W-1:0] dot; } tap_t;
    typedef struct { logic [N*W-1:0] vec; logic sat; } layer_t;

    tap_t           taps[$];
    layer_t         sb[$];
    int             edge_cnt = 0;
    int             issued = 0;
    int             results = 0;
    bit             m_full = 1'b0;
    bit             m_sat = 1'b0;
    logic [N*W-1:0] m_vec = '0;
    logic [W-1:0]   next_dot = '0;
    int             issue_pct = 0;
    int             ready_pct = 0;
    int             checks = 0;
    int             errors = 0;

    function automatic logic [W-1:0] ref_activation(input logic [W-1:0] dot, input logic [W-1:0] bias,
                                                    output bit clip);
        int s;
        s    = int'($signed(dot)) + int'($signed(bias));
        clip = 1'b0;
        if (s > 2**(W-1) - 1) begin
            s = 2**(W-1) - 1;
            clip = 1'b1;
        end else if (s < -(2**(W-1))) begin
            s = -(2**(W-1));
            clip = 1'b1;
        end
`ifdef ACT_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[W-1:0];
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, got, exp);
        end
    endtask

    // Reference model: advances one clock edge using the inputs the bench drove.
    task automatic model_edge();
        bit   ready_before;
        bit   clip;
        tap_t t;
        edge_cnt++;
        if (reset) begin
            taps.delete();
            sb.delete();
            issued  = 0;
            results = 0;
            m_full  = 1'b0;
            m_sat   = 1'b0;
            m_vec   = '0;
        end else begin
            ready_before = !m_full && (issued < N);
            if (m_full && layer_ready) begin
                m_full  = 1'b0;
                issued  = 0;
                results = 0;
                m_sat   = 1'b0;
            end else if (taps.size() > 0 && taps[0].edge_no == edge_cnt) begin
                t = taps.pop_front();
                m_vec[results*W +: W] = ref_activation(t.dot, t.bias, clip);
                m_sat = m_sat | clip;
                results++;
                if (results == N) begin
                    m_full = 1'b1;
                    sb.push_back('{m_vec, m_sat});
                end
            end
            if (issue && ready_before) begin
                issued++;
                taps.push_back('{edge_cnt + L, bias_in, next_dot});
            end
        end
    endtask

    task automatic apply_stimulus();
        logic [W-1:0] b;
        logic [W-1:0] d;
        case ($urandom_range(5))
            0:       begin b = 16'h0200; d = 16'h7F00; end
            1:       begin b = 16'hFE00; d = 16'h8100; end
            2:       begin b = 16'h0000; d = 16'hFF00; end
            3:       begin b = 16'h0100; d = 16'h0200; end
            default: begin b = W'($urandom); d = W'($urandom); end
        endcase
        issue       = ($urandom_range(99) < issue_pct);
        bias_in     = b;
        next_dot    = d;
        layer_ready = ($urandom_range(99) < ready_pct);
        if (taps.size() > 0 && taps[0].edge_no == edge_cnt + 1) dot_in = taps[0].dot;
        else                                                  dot_in = W'($urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        apply_stimulus();
    endtask

    task automatic check_output();
        layer_t e;
        check_bit("issue_ready", issue_ready, !m_full && (issued < N));
        check_bit("layer_valid", layer_valid, m_full);
        check_bit("sat_flag", sat_flag, m_sat);
        check_vec("layer_out", layer_out, m_vec);
        if (layer_valid && layer_ready && !reset) begin
            if (sb.size() == 0) begin
                check_bit("unexpected_layer", layer_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_vec("handshake_vector", layer_out, e.vec);
                check_bit("handshake_sat", sat_flag, e.sat);
            end
        end
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each handshake.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_output();
        end
    end

    initial begin
        reset = 1'b1;
        issue = 1'b0;
        bias_in = '0;
        dot_in = '0;
        layer_ready = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        issue_pct = 70;
        ready_pct = 40;
        repeat (1200) cycle();

        // Fill a layer under backpressure, then hold it while issues keep arriving.
        issue_pct = 100;
        ready_pct = 0;
        for (int i = 0; i < 200 && !m_full; i++) cycle();
        check_bit("fill_layer_valid", layer_valid, 1'b1);
        repeat (20) cycle();
        ready_pct = 100;
        cycle();
        ready_pct = 50;
        issue_pct = 70;
        repeat (60) cycle();

        // Abort a burst of in-flight issues with reset.
        issue_pct = 0;
        ready_pct = 100;
        repeat (30) cycle();
        issue_pct = 100;
        repeat (5) cycle();
        issue_pct = 0;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (15) cycle();
        issue_pct = 70;
        ready_pct = 50;
        repeat (600) cycle();

        issue_pct = 0;
        ready_pct = 100;
        repeat (40) cycle();
        check_bit("scoreboard_drained", sb.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
